// File: rtl/axis_3x32_to_48_unpack_pkg.sv
// Shared widths and byte-packing slices for the 48-bit <-> 3x32-bit stream converters.
// Both the packer and this unpacker take their slice positions from here.
package axis_3x32_to_48_unpack_pkg;

    localparam int BYTE_WIDTH                 = 8;
    localparam int CSA_OUT_DATA_WIDTH_BY_BYTE = 6;
    localparam int CSA_OUT_WIDTH              = BYTE_WIDTH * CSA_OUT_DATA_WIDTH_BY_BYTE;
    localparam int AXIS_WORD_WIDTH            = 32;
    localparam int AXIS_STRB_WIDTH            = AXIS_WORD_WIDTH / BYTE_WIDTH;
    localparam int HALF_WIDTH                 = AXIS_WORD_WIDTH / 2;

    // Little-endian placement of the split middle word across the two records
    localparam int REC0_HI_LSB = 0;
    localparam int REC1_LO_LSB = 16;

    typedef logic [AXIS_WORD_WIDTH-1:0] word_t;
    typedef logic [AXIS_STRB_WIDTH-1:0] strb_t;
    typedef logic [HALF_WIDTH-1:0]      half_t;
    typedef logic [CSA_OUT_WIDTH-1:0]   rec_t;

    typedef enum logic [1:0] {
        PH_W0 = 2'd0,
        PH_W1 = 2'd1,
        PH_W2 = 2'd2
    } phase_e;

    function automatic rec_t pack_rec0(input word_t w0, input word_t w1);
        return {w1[REC0_HI_LSB +: HALF_WIDTH], w0};
    endfunction

    function automatic rec_t pack_rec1(input half_t w1_hi, input word_t w2);
        return {w2, w1_hi};
    endfunction

endpackage

// File: rtl/axis_3x32_to_48_unpack_if.sv
// Word stream in (AXIS slave side) and record stream out for the 3x32-to-48 unpacker.
// The slave modport is the unpacker's view; master is the driving/consuming environment.
interface axis_3x32_to_48_unpack_if;
    import axis_3x32_to_48_unpack_pkg::*;

    logic  s00_axis_tvalid;
    logic  s00_axis_tready;
    word_t s00_axis_tdata;
    strb_t s00_axis_tstrb;
    logic  s00_axis_tlast;

    logic  out_valid;
    logic  out_ready;
    rec_t  out_data;
    logic  out_last;

    modport slave (
        input  s00_axis_tvalid,
        output s00_axis_tready,
        input  s00_axis_tdata,
        input  s00_axis_tstrb,
        input  s00_axis_tlast,
        output out_valid,
        input  out_ready,
        output out_data,
        output out_last
    );

    modport master (
        output s00_axis_tvalid,
        input  s00_axis_tready,
        output s00_axis_tdata,
        output s00_axis_tstrb,
        output s00_axis_tlast,
        input  out_valid,
        output out_ready,
        input  out_data,
        input  out_last
    );

endinterface

// File: rtl/axis_3x32_to_48_unpack_stats.sv
// Record counter (wrapping) and framing-error counter (saturating) with a clear that
// takes priority over any event landing in the same cycle.
module axis_unpack_stats #(
    parameter int CNT_WIDTH     = 32,
    parameter int ERR_CNT_WIDTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     clr_stats_i,
    input  logic                     rec_evt_i,
    input  logic                     err_a_i,
    input  logic                     err_b_i,
    output logic [CNT_WIDTH-1:0]     rec_count_o,
    output logic [ERR_CNT_WIDTH-1:0] err_count_o
);

    logic [CNT_WIDTH-1:0]     rec_count_q, rec_count_d;
    logic [ERR_CNT_WIDTH-1:0] err_count_q, err_count_d;
    logic [1:0]               err_inc;
    logic [ERR_CNT_WIDTH:0]   err_sum;

    // One extra bit on the sum catches overflow, including the +2 case near all-ones
    assign err_inc = {1'b0, err_a_i} + {1'b0, err_b_i};
    assign err_sum = {1'b0, err_count_q} + {{(ERR_CNT_WIDTH-1){1'b0}}, err_inc};

    always_comb begin
        rec_count_d = rec_count_q;
        err_count_d = err_count_q;
        if (clr_stats_i) begin
            rec_count_d = '0;
            err_count_d = '0;
        end else begin
            if (rec_evt_i) begin
                rec_count_d = rec_count_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end
            if (err_sum[ERR_CNT_WIDTH]) begin
                err_count_d = '1;
            end else begin
                err_count_d = err_sum[ERR_CNT_WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rec_count_q <= '0;
            err_count_q <= '0;
        end else begin
            rec_count_q <= rec_count_d;
            err_count_q <= err_count_d;
        end
    end

    assign rec_count_o = rec_count_q;
    assign err_count_o = err_count_q;

endmodule

// File: rtl/axis_3x32_to_48_unpack.sv
// Reassembles every three 32-bit AXIS words into two 48-bit CSA records.
// phase | meaning
// PH_W0 | expecting w0; beat only captures it into hold32
// PH_W1 | expecting w1; beat emits rec0 and keeps w1[31:16] in hold16
// PH_W2 | expecting w2; beat emits rec1
module axis_3x32_to_48_unpack
    import axis_3x32_to_48_unpack_pkg::*;
#(
    parameter int C_S00_AXIS_TDATA_WIDTH = 32,
    parameter int CNT_WIDTH              = 32,
    parameter int ERR_CNT_WIDTH          = 16
) (
    input  logic                        s00_axis_aclk,
    input  logic                        s00_axis_aresetn,
    axis_3x32_to_48_unpack_if.slave     bus,
    input  logic                        clr_stats,
    output logic                        err_partial,
    output logic                        err_strb,
    output logic [CNT_WIDTH-1:0]        rec_count,
    output logic [ERR_CNT_WIDTH-1:0]    err_count
);

    if (C_S00_AXIS_TDATA_WIDTH != AXIS_WORD_WIDTH) begin : g_width_check
        $error("axis_3x32_to_48_unpack supports only a 32-bit input word");
    end

    logic   aresetn_q;
    phase_e phase_q, phase_d;
    word_t  hold32_q, hold32_d;
    half_t  hold16_q, hold16_d;
    logic   out_valid_q, out_valid_d;
    rec_t   out_data_q, out_data_d;
    logic   out_last_q, out_last_d;
    logic   err_partial_q, err_partial_d;
    logic   err_strb_q, err_strb_d;
    logic   tready;
    logic   beat;

    // A phase-0 beat never touches the output register, so it may proceed while a record is held
    assign tready = aresetn_q && ((phase_q == PH_W0) || !out_valid_q || bus.out_ready);
    assign beat   = bus.s00_axis_tvalid && tready;

    always_comb begin
        phase_d       = phase_q;
        hold32_d      = hold32_q;
        hold16_d      = hold16_q;
        out_valid_d   = out_valid_q && !bus.out_ready;
        out_data_d    = out_data_q;
        out_last_d    = out_last_q;
        err_partial_d = 1'b0;
        err_strb_d    = 1'b0;
        if (beat) begin
            err_strb_d = (bus.s00_axis_tstrb != '1);
            case (phase_q)
                PH_W0: begin
                    if (bus.s00_axis_tlast) begin
                        err_partial_d = 1'b1;
                    end else begin
                        hold32_d = bus.s00_axis_tdata;
                        phase_d  = PH_W1;
                    end
                end
                PH_W1: begin
                    out_data_d  = pack_rec0(hold32_q, bus.s00_axis_tdata);
                    out_valid_d = 1'b1;
                    out_last_d  = bus.s00_axis_tlast;
                    if (bus.s00_axis_tlast) begin
                        err_partial_d = 1'b1;
                        phase_d       = PH_W0;
                    end else begin
                        hold16_d = bus.s00_axis_tdata[REC1_LO_LSB +: HALF_WIDTH];
                        phase_d  = PH_W2;
                    end
                end
                PH_W2: begin
                    out_data_d  = pack_rec1(hold16_q, bus.s00_axis_tdata);
                    out_valid_d = 1'b1;
                    out_last_d  = bus.s00_axis_tlast;
                    phase_d     = PH_W0;
                end
                default: begin
                    phase_d = PH_W0;
                end
            endcase
        end
    end

    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            aresetn_q     <= 1'b0;
            phase_q       <= PH_W0;
            hold32_q      <= '0;
            hold16_q      <= '0;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            out_last_q    <= 1'b0;
            err_partial_q <= 1'b0;
            err_strb_q    <= 1'b0;
        end else begin
            aresetn_q     <= 1'b1;
            phase_q       <= phase_d;
            hold32_q      <= hold32_d;
            hold16_q      <= hold16_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            out_last_q    <= out_last_d;
            err_partial_q <= err_partial_d;
            err_strb_q    <= err_strb_d;
        end
    end

    assign bus.s00_axis_tready = tready;
    assign bus.out_valid       = out_valid_q;
    assign bus.out_data        = out_data_q;
    assign bus.out_last        = out_last_q;
    assign err_partial         = err_partial_q;
    assign err_strb            = err_strb_q;

    axis_unpack_stats #(
        .CNT_WIDTH     (CNT_WIDTH),
        .ERR_CNT_WIDTH (ERR_CNT_WIDTH)
    ) u_stats (
        .clk_i       (s00_axis_aclk),
        .rst_n_i     (s00_axis_aresetn),
        .clr_stats_i (clr_stats),
        .rec_evt_i   (out_valid_q && bus.out_ready),
        .err_a_i     (err_partial_q),
        .err_b_i     (err_strb_q),
        .rec_count_o (rec_count),
        .err_count_o (err_count)
    );

endmodule

// File: tb/tb_axis_3x32_to_48_unpack.sv
// Bench for axis_3x32_to_48_unpack: directed framing cases plus random frames,
// checked against a word-list model of the record reassembly and error statistics.
module tb_axis_3x32_to_48_unpack;
    import axis_3x32_to_48_unpack_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr_stats;
    logic        err_partial;
    logic        err_strb;
    logic [31:0] rec_count;
    logic [15:0] err_count;

    axis_3x32_to_48_unpack_if bus ();

    axis_3x32_to_48_unpack #(
        .C_S00_AXIS_TDATA_WIDTH (32),
        .CNT_WIDTH              (32),
        .ERR_CNT_WIDTH          (16)
    ) dut (
        .s00_axis_aclk    (clk),
        .s00_axis_aresetn (rst_n),
        .bus              (bus),
        .clr_stats        (clr_stats),
        .err_partial      (err_partial),
        .err_strb         (err_strb),
        .rec_count        (rec_count),
        .err_count        (err_count)
    );

    always #5 clk = ~clk;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [48:0] exp_q[$];
    logic [48:0] obs_log[$];
    logic [31:0] frame_w[$];
    int          model_recs   = 0;
    int          exp_err      = 0;
    int          exp_partial  = 0;
    int          exp_strb     = 0;
    int          seen_partial = 0;
    int          seen_strb    = 0;
    bit          rand_ready   = 1'b0;
    bit          beat_seen    = 1'b0;
    bit          hold_pend    = 1'b0;
    logic [48:0] hold_val     = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: collect the words of the current group; records are pure arithmetic on them
    task automatic model_beat(input logic [31:0] d, input logic [3:0] s, input logic l);
        logic [47:0] r;
        frame_w.push_back(d);
        if (s != 4'hF) begin
            exp_strb++;
            exp_err++;
        end
        if (frame_w.size() == 2) begin
            r = ((48'(frame_w[1]) & 48'hFFFF) << 32) | 48'(frame_w[0]);
            exp_q.push_back({l, r});
            model_recs++;
        end else if (frame_w.size() == 3) begin
            r = (48'(frame_w[2]) << 16) | (48'(frame_w[1]) >> 16);
            exp_q.push_back({l, r});
            model_recs++;
        end
        if (l && frame_w.size() < 3) begin
            exp_partial++;
            exp_err++;
        end
        if (l || frame_w.size() == 3) frame_w.delete();
    endtask

    task automatic cycle();
        logic        beat;
        logic [48:0] e;
        @(negedge clk);
        if (rst_n === 1'b1) begin
            if (hold_pend) begin
                check("hold_valid", 64'(bus.out_valid), 64'd1);
                check("hold_data", 64'({bus.out_last, bus.out_data}), 64'(hold_val));
            end
            if (err_partial === 1'b1) seen_partial++;
            if (err_strb === 1'b1) seen_strb++;
            if (bus.out_valid && bus.out_ready) begin
                check("rec_expected_pending", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("rec_data", 64'({bus.out_last, bus.out_data}), 64'(e));
                end
                obs_log.push_back({bus.out_last, bus.out_data});
            end
            hold_pend = bus.out_valid && !bus.out_ready;
            hold_val  = {bus.out_last, bus.out_data};
        end else begin
            hold_pend = 1'b0;
        end
        beat = bus.s00_axis_tvalid && bus.s00_axis_tready;
        @(posedge clk);
        beat_seen = beat && (rst_n === 1'b1);
        if (beat_seen) model_beat(bus.s00_axis_tdata, bus.s00_axis_tstrb, bus.s00_axis_tlast);
        #1;
        if (rand_ready) bus.out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send_word(input logic [31:0] d, input logic [3:0] s, input logic l);
        bus.s00_axis_tvalid = 1'b1;
        bus.s00_axis_tdata  = d;
        bus.s00_axis_tstrb  = s;
        bus.s00_axis_tlast  = l;
        for (int i = 0; i < 60; i++) begin
            cycle();
            if (beat_seen) break;
        end
        check("send_accept", 64'(beat_seen), 64'd1);
    endtask

    task automatic idle(input int n);
        bus.s00_axis_tvalid = 1'b0;
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic quiesce(input string tag);
        bus.s00_axis_tvalid = 1'b0;
        rand_ready    = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 30; i++) begin
            cycle();
            if (exp_q.size() == 0 && !bus.out_valid) break;
        end
        cycle();
        cycle();
        check({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
        check({tag, "_rec_count"}, 64'(rec_count), 64'(32'(model_recs)));
        check({tag, "_err_count"}, 64'(err_count), (exp_err > 65535) ? 64'hFFFF : 64'(exp_err));
        check({tag, "_partial_pulses"}, 64'(seen_partial), 64'(exp_partial));
        check({tag, "_strb_pulses"}, 64'(seen_strb), 64'(exp_strb));
    endtask

    task automatic clear_stats();
        bus.s00_axis_tvalid = 1'b0;
        clr_stats = 1'b1;
        cycle();
        clr_stats  = 1'b0;
        model_recs = 0;
        exp_err    = 0;
    endtask

    task automatic random_group();
        for (int k = 0; k < 3; k++) send_word($urandom, 4'hF, k == 2);
    endtask

    initial begin
        int len;
        rst_n               = 1'b0;
        clr_stats           = 1'b0;
        bus.s00_axis_tvalid = 1'b0;
        bus.s00_axis_tdata  = '0;
        bus.s00_axis_tstrb  = 4'hF;
        bus.s00_axis_tlast  = 1'b0;
        bus.out_ready       = 1'b0;
        cycle();
        cycle();
        check("rst_tready", 64'(bus.s00_axis_tready), 64'd0);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_data", 64'({bus.out_last, bus.out_data}), 64'd0);
        check("rst_err_pulses", 64'({err_partial, err_strb}), 64'd0);
        check("rst_counts", 64'({rec_count, err_count}), 64'd0);
        rst_n = 1'b1;
        check("rst_release_tready", 64'(bus.s00_axis_tready), 64'd0);
        cycle();
        check("post_rst_tready", 64'(bus.s00_axis_tready), 64'd1);

        // Basic group at full throughput
        bus.out_ready = 1'b1;
        obs_log.delete();
        send_word(32'h33221100, 4'hF, 1'b0);
        send_word(32'h77665544, 4'hF, 1'b0);
        send_word(32'hBBAA9988, 4'hF, 1'b1);
        quiesce("basic");
        check("basic_nrec", 64'(obs_log.size()), 64'd2);
        check("basic_rec0", 64'(obs_log[0]), 64'({1'b0, 48'h554433221100}));
        check("basic_rec1", 64'(obs_log[1]), 64'({1'b1, 48'hBBAA99887766}));

        // Downstream stall holds rec0 and blocks w2
        obs_log.delete();
        bus.out_ready = 1'b0;
        send_word(32'h33221100, 4'hF, 1'b0);
        send_word(32'h77665544, 4'hF, 1'b0);
        bus.s00_axis_tdata = 32'hBBAA9988;
        bus.s00_axis_tlast = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cycle();
            check("stall_tready", 64'(bus.s00_axis_tready), 64'd0);
            check("stall_out_data", 64'(bus.out_data), 64'h554433221100);
        end
        bus.out_ready = 1'b1;
        send_word(32'hBBAA9988, 4'hF, 1'b1);
        quiesce("stall");
        check("stall_nrec", 64'(obs_log.size()), 64'd2);
        check("stall_rec0", 64'(obs_log[0]), 64'({1'b0, 48'h554433221100}));
        check("stall_rec1", 64'(obs_log[1]), 64'({1'b1, 48'hBBAA99887766}));

        // Two-word frame: rec0 carries tlast, partial error
        obs_log.delete();
        send_word(32'h00000001, 4'hF, 1'b0);
        send_word(32'hFFFF0002, 4'hF, 1'b1);
        quiesce("partial2");
        check("partial2_nrec", 64'(obs_log.size()), 64'd1);
        check("partial2_rec", 64'(obs_log[0]), 64'({1'b1, 48'h000200000001}));
        check("partial2_err_count", 64'(err_count), 64'd1);
        random_group();
        quiesce("after_partial2");

        // Single-word frame
        obs_log.delete();
        send_word($urandom, 4'hF, 1'b1);
        quiesce("partial1");
        check("partial1_nrec", 64'(obs_log.size()), 64'd0);
        check("partial1_err_count", 64'(err_count), 64'd2);
        random_group();
        quiesce("after_partial1");

        // Bad strobe on w1
        obs_log.delete();
        send_word($urandom, 4'hF, 1'b0);
        send_word($urandom, 4'h7, 1'b0);
        send_word($urandom, 4'hF, 1'b1);
        quiesce("strb");
        check("strb_nrec", 64'(obs_log.size()), 64'd2);
        check("strb_err_count", 64'(err_count), 64'd3);

        // Clear coinciding with a record handshake and with an error pulse
        bus.out_ready = 1'b0;
        send_word($urandom, 4'hF, 1'b0);
        send_word($urandom, 4'hF, 1'b0);
        bus.out_ready = 1'b1;
        clear_stats();
        send_word($urandom, 4'hF, 1'b1);
        quiesce("clr_rec");
        check("clr_rec_count", 64'(rec_count), 64'd1);
        send_word($urandom, 4'h3, 1'b1);
        clear_stats();
        quiesce("clr_err");
        check("clr_err_count", 64'(err_count), 64'd0);

        // Random frames with random backpressure and occasional bad strobes
        rand_ready = 1'b1;
        for (int f = 0; f < 40; f++) begin
            len = $urandom_range(1, 7);
            for (int k = 0; k < len; k++) begin
                send_word($urandom,
                          ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 14)) : 4'hF,
                          k == len - 1);
            end
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        quiesce("random");

        // Error counter saturation: 2^16+3 events, crossing all-ones with a +2 step
        clear_stats();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 32767; i++) send_word($urandom, 4'h0, 1'b1);
        quiesce("sat_near");
        check("sat_near_value", 64'(err_count), 64'hFFFE);
        send_word($urandom, 4'h0, 1'b1);
        quiesce("sat_cross");
        check("sat_cross_value", 64'(err_count), 64'hFFFF);
        for (int i = 0; i < 3; i++) send_word($urandom, 4'hF, 1'b1);
        quiesce("sat_hold");
        check("sat_hold_value", 64'(err_count), 64'hFFFF);

        // Asynchronous reset after w0,w1 with rec0 held
        bus.out_ready = 1'b0;
        send_word(32'hDEADBEEF, 4'hF, 1'b0);
        send_word(32'hCAFEF00D, 4'hF, 1'b0);
        check("pre_arst_valid", 64'(bus.out_valid), 64'd1);
        bus.s00_axis_tvalid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", 64'(bus.out_valid), 64'd0);
        check("arst_tready", 64'(bus.s00_axis_tready), 64'd0);
        check("arst_counts", 64'({rec_count, err_count}), 64'd0);
        exp_q.delete();
        frame_w.delete();
        model_recs = 0;
        exp_err    = 0;
        hold_pend  = 1'b0;
        cycle();
        cycle();
        rst_n = 1'b1;
        cycle();
        obs_log.delete();
        bus.out_ready = 1'b1;
        send_word(32'h03020100, 4'hF, 1'b0);
        send_word(32'h07060504, 4'hF, 1'b0);
        send_word(32'h0B0A0908, 4'hF, 1'b1);
        quiesce("post_arst");
        check("post_arst_nrec", 64'(obs_log.size()), 64'd2);
        check("post_arst_rec0", 64'(obs_log[0]), 64'({1'b0, 48'h050403020100}));
        check("post_arst_rec1", 64'(obs_log[1]), 64'({1'b1, 48'h0B0A09080706}));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
